// File: rtl/y_frame_packer.sv
// Hunts the en-qualified y bitstream for SYNC_WORD, then packs the following
// bits MSB-first into BYTES_PER_FRAME bytes before returning to the hunt.
module y_frame_packer #(
    parameter logic [3:0]  SYNC_WORD       = 4'b1011,
    parameter int unsigned BYTES_PER_FRAME = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       y,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_end,
    output logic       locked
);

    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BYTE_W = 4;

    typedef enum logic {
        HUNT = 1'b0,
        PACK = 1'b1
    } state_t;

    state_t              r_state;
    logic [2:0]          r_sreg;
    logic [6:0]          r_shift;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [BYTE_W-1:0]   r_byte_cnt;
    logic [7:0]          r_data;
    logic                r_data_valid;
    logic                r_frame_end;
    logic                r_locked;

    state_t              w_state_nxt;
    logic [2:0]          w_sreg_nxt;
    logic [6:0]          w_shift_nxt;
    logic [BIT_W-1:0]    w_bit_cnt_nxt;
    logic [BYTE_W-1:0]   w_byte_cnt_nxt;
    logic [BYTE_W-1:0]   w_byte_inc;
    logic [7:0]          w_data_nxt;
    logic                w_data_valid_nxt;
    logic                w_frame_end_nxt;

    assign w_byte_inc = r_byte_cnt + BYTE_W'(1);

    // Next-state and output decode; strobes default low so they never hold.
    always_comb begin
        w_state_nxt      = r_state;
        w_sreg_nxt       = r_sreg;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_data_nxt       = r_data;
        w_data_valid_nxt = 1'b0;
        w_frame_end_nxt  = 1'b0;
        if (en) begin
            case (r_state)
                HUNT: begin
                    w_sreg_nxt = {r_sreg[1:0], y};
                    if ({r_sreg, y} == SYNC_WORD) begin
                        w_state_nxt    = PACK;
                        w_sreg_nxt     = 3'd0;
                        w_bit_cnt_nxt  = '0;
                        w_byte_cnt_nxt = '0;
                    end
                end
                PACK: begin
                    w_shift_nxt   = {r_shift[5:0], y};
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    if (r_bit_cnt == BIT_W'(7)) begin
                        w_data_nxt       = {r_shift, y};
                        w_data_valid_nxt = 1'b1;
                        if (w_byte_inc == BYTE_W'(BYTES_PER_FRAME)) begin
                            w_frame_end_nxt = 1'b1;
                            w_state_nxt     = HUNT;
                            w_byte_cnt_nxt  = '0;
                        end else begin
                            w_byte_cnt_nxt  = w_byte_inc;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= HUNT;
            r_sreg       <= 3'd0;
            r_shift      <= 7'd0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_data       <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_end  <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sreg       <= w_sreg_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_data       <= w_data_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_frame_end  <= w_frame_end_nxt;
            r_locked     <= (w_state_nxt == PACK);
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_end  = r_frame_end;
    assign locked     = r_locked;

endmodule
